// File: rtl/simon_pkg.sv
// Shared types and widths for the Simon Says note path.
package simon_pkg;

    localparam int unsigned NOTE_W    = 3;
    localparam int unsigned DUR_W     = 2;
    localparam int unsigned NUM_NOTES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } note_entry_t;

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter; zero is registered and holds once the count expires.
module tick_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            value <= load_value;
            zero  <= (load_value == '0);
        end else if (value != '0) begin
            value <= value - W'(1);
            zero  <= (value == W'(1));
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note buffer plus playback FSM: plays each stored note for its duration,
// then a fixed silent gap, and pulses done at the end.
module note_sequencer import simon_pkg::*; #(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned TICKS_PER_UNIT = 12500000,
    parameter int unsigned GAP_TICKS      = 2500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   append_valid,
    input  logic [NOTE_W-1:0]      append_note,
    input  logic [DUR_W-1:0]       append_dur,
    output logic                   append_ready,
    input  logic                   clear,
    input  logic                   start,
    output logic [NUM_NOTES-1:0]   note_onehot,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam int unsigned MAX_TICKS = (4 * TICKS_PER_UNIT > GAP_TICKS) ? 4 * TICKS_PER_UNIT : GAP_TICKS;
    localparam int unsigned TICK_W    = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

    // Longest load is 4*TICKS_PER_UNIT-1, which TICK_W always holds.
    function automatic logic [TICK_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
        return TICK_W'((32'(d) + 32'd1) * TICKS_PER_UNIT - 32'd1);
    endfunction

    function automatic logic [NUM_NOTES-1:0] onehot(input logic [NOTE_W-1:0] n);
        return NUM_NOTES'(1) << n;
    endfunction

    seq_state_t            state, state_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [CNT_W-1:0]      count_nx;
    logic [NUM_NOTES-1:0]  onehot_nx;
    note_entry_t           buffer [DEPTH];

    logic                  zero;
    logic                  load_c;
    logic [TICK_W-1:0]     load_value_c;
    logic                  wr_en_c;
    logic                  idx_is_last_c;
    logic                  busy_nx_c;
    note_entry_t           app_entry_c, first_entry_c, next_entry_c;

    assign app_entry_c   = '{note: append_note, dur: append_dur};
    assign wr_en_c       = append_valid & append_ready & ~clear;
    assign idx_is_last_c = ({1'b0, idx} == count - CNT_W'(1));
    // A note appended in the same cycle as start must be visible as entry 0.
    assign first_entry_c = (wr_en_c && count == '0) ? app_entry_c : buffer[0];
    assign next_entry_c  = buffer[idx + IDX_W'(1)];
    assign busy_nx_c     = (state_nx == PLAY) || (state_nx == GAP);

    tick_counter #(.W(TICK_W)) u_ticks (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .load_value (load_value_c),
        .zero       (zero)
    );

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        count_nx     = count;
        onehot_nx    = note_onehot;
        load_c       = 1'b0;
        load_value_c = '0;
        if (clear) begin
            state_nx  = IDLE;
            count_nx  = '0;
            onehot_nx = '0;
        end else begin
            if (wr_en_c) count_nx = count + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_nx != '0) begin
                            state_nx     = PLAY;
                            idx_nx       = '0;
                            load_c       = 1'b1;
                            load_value_c = dur_ticks(first_entry_c.dur);
                            onehot_nx    = onehot(first_entry_c.note);
                        end else begin
                            state_nx = FINISH;
                        end
                    end
                end
                PLAY: begin
                    if (zero) begin
                        state_nx     = GAP;
                        load_c       = 1'b1;
                        load_value_c = TICK_W'(GAP_TICKS - 1);
                        onehot_nx    = '0;
                    end
                end
                GAP: begin
                    if (zero) begin
                        if (idx_is_last_c) begin
                            state_nx = FINISH;
                        end else begin
                            state_nx     = PLAY;
                            idx_nx       = idx + IDX_W'(1);
                            load_c       = 1'b1;
                            load_value_c = dur_ticks(next_entry_c.dur);
                            onehot_nx    = onehot(next_entry_c.note);
                        end
                    end
                end
                FINISH: state_nx = IDLE;
                default: begin
                    state_nx  = IDLE;
                    onehot_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            count        <= '0;
            note_onehot  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            append_ready <= 1'b1;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            count        <= count_nx;
            note_onehot  <= onehot_nx;
            busy         <= busy_nx_c;
            done         <= (state_nx == FINISH);
            append_ready <= ~busy_nx_c && (count_nx < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c && !reset) buffer[count[IDX_W-1:0]] <= app_entry_c;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with short tick constants.
module tb_note_sequencer;

    localparam int unsigned TPU   = 4;
    localparam int unsigned GAPT  = 2;
    localparam int unsigned DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       append_valid = 1'b0;
    logic [2:0] append_note = '0;
    logic [1:0] append_dur = '0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       append_ready, busy, done;
    logic [7:0] note_onehot;
    logic [5:0] count;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    note_sequencer #(.DEPTH(DEPTH), .TICKS_PER_UNIT(TPU), .GAP_TICKS(GAPT)) dut (
        .clk          (clk),
        .reset        (reset),
        .append_valid (append_valid),
        .append_note  (append_note),
        .append_dur   (append_dur),
        .append_ready (append_ready),
        .clear        (clear),
        .start        (start),
        .note_onehot  (note_onehot),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    // Monitor: every cycle the DUT is busy or signals done is one scoreboard entry.
    always @(negedge clk) begin
        if (busy === 1'b1 || done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got onehot=%h busy=%b done=%b, expected no activity",
                         note_onehot, busy, done);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({note_onehot, busy, done} !== e) begin
                    errors++;
                    $display("FAIL playback_cycle: got onehot=%h busy=%b done=%b, expected onehot=%h busy=%b done=%b",
                             note_onehot, busy, done, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic push_note(input int n, input int d);
        logic [7:0] oh;
        oh = 8'h01 << n;
        repeat ((d + 1) * TPU) exp_q.push_back({oh, 1'b1, 1'b0});
        repeat (GAPT) exp_q.push_back({8'h00, 1'b1, 1'b0});
    endtask

    task automatic push_done();
        exp_q.push_back({8'h00, 1'b0, 1'b1});
    endtask

    task automatic append(input int n, input int d);
        append_valid = 1'b1;
        append_note  = 3'(n);
        append_dur   = 2'(d);
        tick();
        append_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected cycles still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    task automatic abort_checks(input string tag);
        chk({tag, "_onehot"}, int'(note_onehot), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_ready"}, int'(append_ready), 1);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_onehot", int'(note_onehot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_ready", int'(append_ready), 1);
        reset = 1'b0;
        tick();

        // Single note (5, d0)
        append(5, 0);
        chk("single_count", int'(count), 1);
        push_note(5, 0);
        push_done();
        pulse_start();
        chk("single_latency_busy", int'(busy), 1);
        chk("single_latency_onehot", int'(note_onehot), 'h20);
        drain(50);
        chk("single_count_after", int'(count), 1);
        pulse_clear();
        chk("clear_count", int'(count), 0);

        // Three notes, with a refused append and ignored start mid-play
        append(0, 3);
        append(7, 1);
        append(2, 0);
        push_note(0, 3);
        push_note(7, 1);
        push_note(2, 0);
        push_done();
        pulse_start();
        repeat (4) tick();
        chk("busy_ready_low", int'(append_ready), 0);
        append_valid = 1'b1;
        append_note  = 3'd6;
        append_dur   = 2'd2;
        start        = 1'b1;
        tick();
        append_valid = 1'b0;
        start        = 1'b0;
        chk("busy_append_refused", int'(count), 3);
        drain(100);
        chk("three_count_after", int'(count), 3);

        // Empty start
        pulse_clear();
        push_done();
        pulse_start();
        drain(10);
        chk("empty_count", int'(count), 0);

        // Full buffer
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(DEPTH) - 1) chk("ready_at_31", int'(append_ready), 1);
            append(i % 8, i % 4);
        end
        chk("full_count", int'(count), 32);
        chk("full_ready", int'(append_ready), 0);
        append(1, 1);
        chk("full_drop_count", int'(count), 32);
        pulse_clear();

        // Abort with clear mid-note
        append(0, 3);
        append(7, 1);
        append(2, 0);
        repeat (3) exp_q.push_back({8'h01, 1'b1, 1'b0});
        pulse_start();
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        abort_checks("clear_abort");
        repeat (6) tick();

        // Abort with reset mid-note
        append(0, 3);
        append(7, 1);
        append(2, 0);
        repeat (3) exp_q.push_back({8'h01, 1'b1, 1'b0});
        pulse_start();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        abort_checks("reset_abort");
        repeat (6) tick();

        // Append and start in the same cycle on an empty buffer
        push_note(3, 1);
        push_done();
        append_valid = 1'b1;
        append_note  = 3'd3;
        append_dur   = 2'd1;
        start        = 1'b1;
        tick();
        append_valid = 1'b0;
        start        = 1'b0;
        chk("same_cycle_onehot", int'(note_onehot), 'h08);
        drain(50);
        chk("same_cycle_count", int'(count), 1);
        chk("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
